serial_add_arb: RTL



---
 rtl/serial_add_arb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_add_arb.sv
// Bit-serial adder shared round-robin between two requesters: one full-adder
// slice (two half adders plus an OR) steps the operands LSB-first over WIDTH cycles.
module serial_add_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state_dbg
);

  // Handshake: a request is taken only in IDLE, on an edge where req is high;
  // the winner's gnt pulses for the following cycle, and done pulses WIDTH
  // cycles after that gnt with sum/cout valid and held until the next done.

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a, sh_b, res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             last_id;
  logic             win_id;

  logic             any_req;
  logic             pick;
  logic             last_bit;
  logic             ha1_s, ha1_c, ha2_s, ha2_c, carry_next;

  always_comb begin
    any_req  = req0 | req1;
    // On a tie the requester that did not win last time goes first.
    pick     = (req0 & req1) ? ~last_id : req1;
    last_bit = (cnt == CW'(WIDTH - 1));

    ha1_s      = sh_a[0] ^ sh_b[0];
    ha1_c      = sh_a[0] & sh_b[0];
    ha2_s      = ha1_s ^ carry;
    ha2_c      = ha1_s & carry;
    carry_next = ha1_c | ha2_c;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ADD;
      ADD:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a    <= '0;
      sh_b    <= '0;
      res     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      last_id <= 1'b1;
      win_id  <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            sh_a    <= pick ? a1 : a0;
            sh_b    <= pick ? b1 : b0;
            carry   <= 1'b0;
            cnt     <= '0;
            last_id <= pick;
            win_id  <= pick;
            gnt0    <= ~pick;
            gnt1    <= pick;
          end
        end
        ADD: begin
          // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
          res   <= {ha2_s, res[WIDTH-1:1]};
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          carry <= carry_next;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            sum     <= {ha2_s, res[WIDTH-1:1]};
            cout    <= carry_next;
            done    <= 1'b1;
            done_id <= win_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule
